// File: rtl/md_pkg.sv
// md_pkg: shared definitions for the multiply/divide unit.
// Holds the MDOp encodings (also used by the control-unit decoder), the
// unit's two-state FSM type, the counter width and the combinational
// result helper that evaluates one mult/div operation.
package md_pkg;

    // Busy counter width; covers the 1..15 cycle range of both latencies
    localparam int unsigned CNT_W = 4;

    // MDOp encodings; 7 is reserved and behaves as MD_NONE
    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6,
        MD_RSVD  = 3'd7
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_e;

    // Result of one operation: wr=0 means HI/LO must be left untouched
    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        wr;
    } md_res_t;

    // True for the operations that start a multi-cycle run
    function automatic logic md_is_multicycle(input logic [2:0] op);
        logic r;
        case (op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: r = 1'b1;
            default:                            r = 1'b0;
        endcase
        return r;
    endfunction

    // True for the operations that use the multiply latency
    function automatic logic md_is_mult(input logic [2:0] op);
        logic r;
        case (op)
            MD_MULT, MD_MULTU: r = 1'b1;
            default:           r = 1'b0;
        endcase
        return r;
    endfunction

    // Evaluates the HI/LO result of a mult/div operation
    function automatic md_res_t md_compute(input logic [2:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
        md_res_t            res;
        logic        [63:0] prod;
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        res  = '{hi: 32'd0, lo: 32'd0, wr: 1'b0};
        prod = 64'd0;
        sa   = $signed(a);
        sb   = $signed(b);
        case (op)
            MD_MULT: begin
                // Low 64 bits of the product of sign-extended operands
                // equal the signed 32x32 product
                prod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
                res  = '{hi: prod[63:32], lo: prod[31:0], wr: 1'b1};
            end
            MD_MULTU: begin
                prod = {32'd0, a} * {32'd0, b};
                res  = '{hi: prod[63:32], lo: prod[31:0], wr: 1'b1};
            end
            MD_DIV: begin
                if (b == 32'd0) begin
                    res.wr = 1'b0;
                end else if ((a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) begin
                    // The only overflowing quotient: wraps back to MIN_INT
                    res = '{hi: 32'd0, lo: 32'h8000_0000, wr: 1'b1};
                end else begin
                    res = '{hi: $unsigned(sa % sb), lo: $unsigned(sa / sb), wr: 1'b1};
                end
            end
            MD_DIVU: begin
                if (b == 32'd0) begin
                    res.wr = 1'b0;
                end else begin
                    res = '{hi: a % b, lo: a / b, wr: 1'b1};
                end
            end
            default: res.wr = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/md_unit.sv
// md_unit: E-stage multiply/divide unit owning the HI/LO registers.
// Ports:
//   clk    - clock, all state updates on the rising edge
//   reset  - synchronous active-high reset
//   Start  - one-cycle pulse for mult/multu/div/divu in E
//   MDOp   - operation select (md_op_e encoding)
//   A, B   - forwarded rs / rt operands
//   Busy   - operation in progress
//   HI, LO - architectural HI/LO registers
// The result is computed in the Start cycle and parked in shadow registers;
// a down-counter models the latency and HI/LO are written on its last cycle.
module md_unit
    import md_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    md_state_e          r_state;
    md_state_e          w_state_nx;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nx;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    logic [31:0]        w_hi_nx;
    logic [31:0]        w_lo_nx;
    logic [31:0]        r_hi_t;
    logic [31:0]        r_lo_t;
    logic [31:0]        w_hi_t_nx;
    logic [31:0]        w_lo_t_nx;
    logic               r_wr_t;
    logic               w_wr_t_nx;
    md_res_t            w_res;

    assign w_res = md_compute(MDOp, A, B);

    // Next-state logic: start / mt writes in IDLE, countdown and commit in BUSY
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_hi_nx    = r_hi;
        w_lo_nx    = r_lo;
        w_hi_t_nx  = r_hi_t;
        w_lo_t_nx  = r_lo_t;
        w_wr_t_nx  = r_wr_t;
        case (r_state)
            ST_IDLE: begin
                if (Start) begin
                    if (md_is_multicycle(MDOp)) begin
                        w_state_nx = ST_BUSY;
                        w_hi_t_nx  = w_res.hi;
                        w_lo_t_nx  = w_res.lo;
                        w_wr_t_nx  = w_res.wr;
                        if (md_is_mult(MDOp)) begin
                            w_cnt_nx = CNT_W'(MULT_CYCLES);
                        end else begin
                            w_cnt_nx = CNT_W'(DIV_CYCLES);
                        end
                    end else begin
                        w_state_nx = ST_IDLE;
                    end
                end else begin
                    // mt writes only happen with no Start in flight
                    if (MDOp == MD_MTHI) begin
                        w_hi_nx = A;
                    end else if (MDOp == MD_MTLO) begin
                        w_lo_nx = A;
                    end else begin
                        w_hi_nx = r_hi;
                    end
                end
            end
            ST_BUSY: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nx = ST_IDLE;
                    w_cnt_nx   = CNT_W'(0);
                    // Divide by zero leaves wr clear so HI/LO keep old values
                    if (r_wr_t) begin
                        w_hi_nx = r_hi_t;
                        w_lo_nx = r_lo_t;
                    end else begin
                        w_hi_nx = r_hi;
                    end
                end else begin
                    w_cnt_nx = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_cnt_nx   = CNT_W'(0);
            end
        endcase
    end

    // State, counter, shadow and HI/LO registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= CNT_W'(0);
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_hi_t  <= 32'd0;
            r_lo_t  <= 32'd0;
            r_wr_t  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_hi    <= w_hi_nx;
            r_lo    <= w_lo_nx;
            r_hi_t  <= w_hi_t_nx;
            r_lo_t  <= w_lo_t_nx;
            r_wr_t  <= w_wr_t_nx;
        end
    end

    assign Busy = (r_state == ST_BUSY);
    assign HI   = r_hi;
    assign LO   = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed test of md_unit against a cycle-level model of the
// HI/LO architecture, plus hand-computed literal checks.
module tb_md_unit;

    logic        clk;
    logic        reset;
    logic        Start;
    logic [2:0]  MDOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state
    logic [31:0] m_hi, m_lo, m_pend_hi, m_pend_lo;
    logic        m_pend_wr;
    int          m_left;
    logic        m_valid = 1'b0;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .Start(Start), .MDOp(MDOp),
        .A(A), .B(B), .Busy(Busy), .HI(HI), .LO(LO)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural model: updated from the inputs seen at each rising edge
    always @(posedge clk) begin
        longint          sp;
        longint unsigned up;
        longint          sa, sb;
        if (reset) begin
            m_hi = 32'd0; m_lo = 32'd0; m_left = 0; m_valid = 1'b1;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            if (m_left == 0 && m_pend_wr) begin
                m_hi = m_pend_hi; m_lo = m_pend_lo;
            end
        end else if (Start && MDOp >= 3'd1 && MDOp <= 3'd4) begin
            sa = longint'($signed(A));
            sb = longint'($signed(B));
            m_pend_wr = 1'b1;
            case (MDOp)
                3'd1: begin sp = sa * sb; m_pend_hi = sp[63:32]; m_pend_lo = sp[31:0]; m_left = 5; end
                3'd2: begin up = {32'd0, A} * {32'd0, B}; m_pend_hi = up[63:32]; m_pend_lo = up[31:0]; m_left = 5; end
                3'd3: begin
                    m_left = 10;
                    if (B == 32'd0) m_pend_wr = 1'b0;
                    else begin sp = sa / sb; m_pend_lo = sp[31:0]; sp = sa % sb; m_pend_hi = sp[31:0]; end
                end
                default: begin
                    m_left = 10;
                    if (B == 32'd0) m_pend_wr = 1'b0;
                    else begin m_pend_lo = A / B; m_pend_hi = A % B; end
                end
            endcase
        end else if (!Start && MDOp == 3'd5) begin
            m_hi = A;
        end else if (!Start && MDOp == 3'd6) begin
            m_lo = A;
        end
    end

    // Compare process: every cycle after the first reset edge
    always @(negedge clk) begin
        if (m_valid) begin
            check("busy", {31'd0, Busy}, {31'd0, (m_left > 0)});
            check("hi", HI, m_hi);
            check("lo", LO, m_lo);
        end
    end

    // Issues one op at a negedge and returns the number of Busy cycles seen
    task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, output int nbusy);
        Start = 1'b1; MDOp = op; A = a; B = b;
        @(negedge clk);
        Start = 1'b0; MDOp = 3'd0; A = $urandom; B = $urandom;
        nbusy = 0;
        while (Busy && nbusy < 40) begin
            nbusy++;
            @(negedge clk);
        end
    endtask

    task automatic mt(input logic [2:0] op, input logic [31:0] a);
        Start = 1'b0; MDOp = op; A = a;
        @(negedge clk);
        MDOp = 3'd0;
    endtask

    int nb;

    initial begin
        reset = 1'b1; Start = 1'b0; MDOp = 3'd0; A = 32'd0; B = 32'd0;
        repeat (2) @(negedge clk);
        check("reset_busy", {31'd0, Busy}, 32'd0);
        check("reset_hi", HI, 32'd0);
        check("reset_lo", LO, 32'd0);
        reset = 1'b0;

        mt(3'd5, 32'h0000_ABCD);
        check("mthi", HI, 32'h0000_ABCD);

        run_op(3'd1, 32'hFFFF_FFFD, 32'd5, nb);
        check("mult_cycles", nb, 32'd5);
        check("mult_hi", HI, 32'hFFFF_FFFF);
        check("mult_lo", LO, 32'hFFFF_FFF1);

        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, nb);
        check("multu_hi", HI, 32'hFFFF_FFFE);
        check("multu_lo", LO, 32'h0000_0001);

        run_op(3'd3, 32'hFFFF_FFF9, 32'd2, nb);
        check("div_cycles", nb, 32'd10);
        check("div_lo", LO, 32'hFFFF_FFFD);
        check("div_hi", HI, 32'hFFFF_FFFF);

        run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, nb);
        check("divovf_lo", LO, 32'h8000_0000);
        check("divovf_hi", HI, 32'd0);

        run_op(3'd4, 32'd100, 32'd7, nb);
        check("divu_lo", LO, 32'd14);
        check("divu_hi", HI, 32'd2);

        mt(3'd5, 32'h11);
        mt(3'd6, 32'h22);
        run_op(3'd4, 32'd7, 32'd0, nb);
        check("div0_cycles", nb, 32'd10);
        check("div0_hi", HI, 32'h11);
        check("div0_lo", LO, 32'h22);

        // MULT 4*5 with an MTLO in cycle 2 and a second Start in cycle 3
        Start = 1'b1; MDOp = 3'd1; A = 32'd4; B = 32'd5;
        @(negedge clk);
        Start = 1'b0; MDOp = 3'd0; A = 32'd9;
        @(negedge clk);
        MDOp = 3'd6; A = 32'h999;
        @(negedge clk);
        Start = 1'b1; MDOp = 3'd4; A = 32'd100; B = 32'd3;
        @(negedge clk);
        Start = 1'b0; MDOp = 3'd0;
        check("mtlo_ignored", LO, 32'h22);
        nb = 3;
        while (Busy && nb < 40) begin
            nb++;
            @(negedge clk);
        end
        check("restart_cycles", nb, 32'd5);
        check("restart_lo", LO, 32'd20);
        check("restart_hi", HI, 32'd0);
        repeat (12) @(negedge clk);
        check("no_late_commit_lo", LO, 32'd20);

        // Reset in cycle 3 of a DIV
        Start = 1'b1; MDOp = 3'd3; A = 32'd100; B = 32'd7;
        @(negedge clk);
        Start = 1'b0; MDOp = 3'd0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_mid_busy", {31'd0, Busy}, 32'd0);
        check("rst_mid_hi", HI, 32'd0);
        check("rst_mid_lo", LO, 32'd0);
        repeat (12) @(negedge clk);
        check("rst_no_commit_lo", LO, 32'd0);

        run_op(3'd1, 32'd2, 32'd3, nb);
        check("post_rst_cycles", nb, 32'd5);
        check("post_rst_lo", LO, 32'd6);
        check("post_rst_hi", HI, 32'd0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
